// File: rtl/lift_call_scheduler.sv
// Hall-call scheduler for a 4-floor lift: deduplicates button presses, queues them in arrival order
// and offers them one at a time to the lift controller over a valid/ready interface.
module lift_call_scheduler #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] i_req_btn,
    input  logic       i_cancel_all,
    input  logic       i_cmd_ready,
    output logic [2:0] o_cmd,
    output logic       o_cmd_valid,
    output logic       o_q_empty,
    output logic [5:0] o_lamp,
    output logic [2:0] o_q_count,
    output logic       o_stall
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StOffer, StGap} state_t;

    // Button index -> request code sent to the controller.
    function automatic logic [2:0] f_code(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = 3'b001;
            3'd1:    code = 3'b010;
            3'd2:    code = 3'b011;
            3'd3:    code = 3'b110;
            3'd4:    code = 3'b111;
            3'd5:    code = 3'b100;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    // Request code -> one-hot pending bit.
    function automatic logic [5:0] f_onehot(input logic [2:0] code);
        logic [5:0] oh;
        case (code)
            3'b001:  oh = 6'b000001;
            3'b010:  oh = 6'b000010;
            3'b011:  oh = 6'b000100;
            3'b110:  oh = 6'b001000;
            3'b111:  oh = 6'b010000;
            3'b100:  oh = 6'b100000;
            default: oh = 6'b000000;
        endcase
        return oh;
    endfunction

    logic [5:0]  r_pending;
    logic [5:0]  r_arrived;
    logic [2:0]  r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    state_t      r_state;
    logic [2:0]  r_cmd;
    logic        r_cmd_valid;
    logic [7:0]  r_wdog;
    logic        r_stall;

    logic        w_flush;
    logic        w_accept;
    logic [5:0]  w_clr;
    logic [5:0]  w_set;
    logic        w_wr_en;
    logic [2:0]  w_scan_idx;
    logic [5:0]  w_scan_clr;
    logic        w_empty;
    logic        w_full;
    logic [2:0]  w_head;
    logic [2:0]  w_count;

    assign w_flush  = !rst_n || i_cancel_all;
    assign w_accept = r_cmd_valid && i_cmd_ready;
    assign w_clr    = w_accept ? f_onehot(r_cmd) : 6'b000000;
    // A press landing on the accept edge of the same code re-arms it as a fresh call.
    assign w_set    = i_req_btn & (~r_pending | w_clr);

    always_comb begin
        w_wr_en    = 1'b0;
        w_scan_idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (r_arrived[i]) begin
                w_wr_en    = 1'b1;
                w_scan_idx = 3'(i);
            end
        end
    end

    assign w_scan_clr = w_wr_en ? (6'b000001 << w_scan_idx) : 6'b000000;
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_head     = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_pending <= 6'b000000;
            r_arrived <= 6'b000000;
            r_wptr    <= '0;
            r_rptr    <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
            r_arrived <= (r_arrived & ~w_scan_clr) | w_set;
            if (w_wr_en) begin
                r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_accept) begin
                r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr[AW-1:0]] <= f_code(w_scan_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_state     <= StIdle;
            r_cmd       <= 3'b000;
            r_cmd_valid <= 1'b0;
            r_wdog      <= 8'd0;
            r_stall     <= 1'b0;
        end else begin
            r_stall <= 1'b0;
            unique case (r_state)
                StIdle, StGap: begin
                    if (!w_empty) begin
                        r_state     <= StOffer;
                        r_cmd       <= w_head;
                        r_cmd_valid <= 1'b1;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StOffer: begin
                    if (i_cmd_ready) begin
                        r_state     <= StGap;
                        r_cmd       <= 3'b000;
                        r_cmd_valid <= 1'b0;
                        r_wdog      <= 8'd0;
                    end else if (r_wdog == 8'(TIMEOUT - 1)) begin
                        r_wdog  <= 8'd0;
                        r_stall <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        w_count = 3'd0;
        for (int i = 0; i < 6; i++) begin
            w_count = w_count + {2'b00, r_pending[i]};
        end
    end

    assign o_cmd       = r_cmd;
    assign o_cmd_valid = r_cmd_valid;
    assign o_q_empty   = (r_pending == 6'b000000);
    assign o_lamp      = r_pending;
    assign o_q_count   = w_count;
    assign o_stall     = r_stall;

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_wr_en && w_full))
        else $error("call fifo written while full");
`endif

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Self-checking bench for lift_call_scheduler: directed scenarios plus a randomized run, all
// compared every cycle against a queue-based reference model.
module tb_lift_call_scheduler;
    localparam int unsigned TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] req_btn = 6'b000000;
    logic       cancel_all = 1'b0;
    logic       cmd_ready = 1'b0;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       q_empty;
    logic [5:0] lamp;
    logic [2:0] q_count;
    logic       stall;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    lift_call_scheduler #(.DEPTH(8), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_btn   (req_btn),
        .i_cancel_all(cancel_all),
        .i_cmd_ready (cmd_ready),
        .o_cmd       (cmd),
        .o_cmd_valid (cmd_valid),
        .o_q_empty   (q_empty),
        .o_lamp      (lamp),
        .o_q_count   (q_count),
        .o_stall     (stall)
    );

    // Reference model: pending/arrived sets, an arrival-ordered queue of button indices,
    // and whether a call is currently offered.
    logic [2:0] codes [6] = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b100};
    bit [5:0] m_pend = '0;
    bit [5:0] m_arr = '0;
    int       m_q[$];
    bit       m_offer = 0;
    int       m_idx = 0;
    int       m_wait = 0;
    bit       m_stall = 0;

    task automatic model_edge(input logic rstn, input logic [5:0] req, input logic cancel,
                              input logic ready);
        bit       acc;
        bit [5:0] newp;
        bit       had_calls;
        if (!rstn || cancel) begin
            m_pend = '0; m_arr = '0; m_q.delete();
            m_offer = 0; m_wait = 0; m_stall = 0;
            return;
        end
        acc = m_offer && ready;
        newp = req & ~m_pend;
        if (acc) newp[m_idx] = req[m_idx];
        had_calls = (m_q.size() > 0);
        m_stall = 0;
        if (m_offer) begin
            if (acc) begin
                void'(m_q.pop_front());
                m_pend[m_idx] = 0;
                m_offer = 0;
                m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    m_stall = 1;
                    m_wait = 0;
                end
            end
        end else if (had_calls) begin
            m_offer = 1;
            m_idx = m_q[0];
        end
        for (int i = 0; i < 6; i++) begin
            if (m_arr[i]) begin
                m_q.push_back(i);
                m_arr[i] = 0;
                break;
            end
        end
        m_arr |= newp;
        m_pend |= newp;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [2:0] exp_cmd;
        exp_cmd = m_offer ? codes[m_idx] : 3'b000;
        chk("cmd", 8'(cmd), 8'(exp_cmd));
        chk("cmd_valid", 8'(cmd_valid), 8'(m_offer));
        chk("lamp", 8'(lamp), 8'(m_pend));
        chk("q_count", 8'(q_count), 8'($countones(m_pend)));
        chk("q_empty", 8'(q_empty), 8'(m_pend == 0));
        chk("stall", 8'(stall), 8'(m_stall));
    endtask

    task automatic step(input logic [5:0] req, input logic cancel, input logic ready,
                        input logic rstn);
        rst_n = rstn;
        req_btn = req;
        cancel_all = cancel;
        cmd_ready = ready;
        @(posedge clk);
        model_edge(rstn, req, cancel, ready);
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic wait_valid(input logic ready, input int max_cyc);
        for (int k = 0; k < max_cyc && !cmd_valid; k++) step(6'b000000, 1'b0, ready, 1'b1);
        chk("wait_valid", 8'(cmd_valid), 8'd1);
    endtask

    initial begin
        int stall_seen;
        int issued;
        logic [5:0] rq;

        // Reset with buttons mashed: presses must be discarded.
        for (int k = 0; k < 3; k++) step(6'b111111, 1'b0, 1'b0, 1'b0);
        chk("rst_cmd", 8'(cmd), 8'd0);
        chk("rst_valid", 8'(cmd_valid), 8'd0);
        chk("rst_q_empty", 8'(q_empty), 8'd1);
        chk("rst_lamp", 8'(lamp), 8'd0);
        chk("rst_q_count", 8'(q_count), 8'd0);
        chk("rst_stall", 8'(stall), 8'd0);

        // Single 3U press: valid three cycles after the capture edge.
        step(6'b000100, 1'b0, 1'b1, 1'b1);
        chk("t1_lamp", 8'(lamp), 8'h04);
        step(6'b000000, 1'b0, 1'b1, 1'b1);
        chk("t1_novalid", 8'(cmd_valid), 8'd0);
        step(6'b000000, 1'b0, 1'b1, 1'b1);
        chk("t1_valid", 8'(cmd_valid), 8'd1);
        chk("t1_cmd", 8'(cmd), 8'h03);
        step(6'b000000, 1'b0, 1'b1, 1'b1);
        chk("t1_lamp_clr", 8'(lamp), 8'd0);
        chk("t1_q_empty", 8'(q_empty), 8'd1);

        // 4D + 1U together: index order, one gap cycle between issues.
        step(6'b100001, 1'b0, 1'b1, 1'b1);
        chk("t2_cnt2", 8'(q_count), 8'd2);
        step(6'b000000, 1'b0, 1'b1, 1'b1);
        step(6'b000000, 1'b0, 1'b1, 1'b1);
        chk("t2_cmd_1u", 8'(cmd), 8'h01);
        step(6'b000000, 1'b0, 1'b1, 1'b1);
        chk("t2_gap", 8'(cmd_valid), 8'd0);
        chk("t2_cnt1", 8'(q_count), 8'd1);
        step(6'b000000, 1'b0, 1'b1, 1'b1);
        chk("t2_cmd_4d", 8'(cmd), 8'h04);
        step(6'b000000, 1'b0, 1'b1, 1'b1);
        chk("t2_cnt0", 8'(q_count), 8'd0);

        // Held 2U button counts once; then watchdog with the call left unaccepted.
        for (int k = 0; k < 10; k++) step(6'b000010, 1'b0, 1'b0, 1'b1);
        chk("t3_lamp", 8'(lamp), 8'h02);
        chk("t3_cnt", 8'(q_count), 8'd1);
        stall_seen = 0;
        for (int k = 0; k < 300; k++) begin
            step(6'b000000, 1'b0, 1'b0, 1'b1);
            if (stall) stall_seen++;
        end
        chk("t4_stall_once", 8'(stall_seen), 8'd1);
        chk("t4_cmd_held", 8'(cmd), 8'h02);
        step(6'b000000, 1'b0, 1'b1, 1'b1);
        issued = 0;
        for (int k = 0; k < 6; k++) begin
            step(6'b000000, 1'b0, 1'b1, 1'b1);
            if (cmd_valid) issued++;
        end
        chk("t3_single_entry", 8'(issued), 8'd0);

        // 2D re-pressed on its own accept edge is re-queued.
        step(6'b001000, 1'b0, 1'b0, 1'b1);
        wait_valid(1'b0, 6);
        chk("t5_cmd", 8'(cmd), 8'h06);
        step(6'b001000, 1'b0, 1'b1, 1'b1);
        chk("t5_pend_kept", 8'(lamp), 8'h08);
        chk("t5_gap", 8'(cmd_valid), 8'd0);
        wait_valid(1'b0, 6);
        chk("t5_reoffer", 8'(cmd), 8'h06);
        step(6'b000000, 1'b0, 1'b1, 1'b1);
        step(6'b000000, 1'b0, 1'b1, 1'b1);
        chk("t5_empty", 8'(q_empty), 8'd1);

        // Three calls queued, flushed mid-offer by cancel_all and then by reset.
        for (int run = 0; run < 2; run++) begin
            step(6'b010110, 1'b0, 1'b0, 1'b1);
            wait_valid(1'b0, 6);
            chk("t6_cnt3", 8'(q_count), 8'd3);
            if (run == 0) step(6'b000000, 1'b1, 1'b1, 1'b1);
            else step(6'b000000, 1'b0, 1'b1, 1'b0);
            chk("t6_valid", 8'(cmd_valid), 8'd0);
            chk("t6_lamp", 8'(lamp), 8'd0);
            chk("t6_q_empty", 8'(q_empty), 8'd1);
            issued = 0;
            for (int k = 0; k < 10; k++) begin
                step(6'b000000, 1'b0, 1'b1, 1'b1);
                if (cmd_valid) issued++;
            end
            chk("t6_none_issued", 8'(issued), 8'd0);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < 6; b++) rq[b] = ($urandom_range(0, 5) == 0);
            step(rq, ($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)),
                 !($urandom_range(0, 299) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
